// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: FSM state codes, debug encoding and 50 MHz timing defaults for the HC-SR04 interface.
package hcsr04_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRIG   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_MEAS   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_CYC_PER_CM  = 2941;
  localparam int DEF_TIMEOUT_CYC = 1500000;
  localparam int DEF_SETTLE_CYC  = 3000000;
  function automatic logic [3:0] db_code(input logic [2:0] s);
    return {1'b0, s};
  endfunction
endpackage

// File: rtl/hcsr04_echo_timer.sv
// hcsr04_echo_timer: echo-high prescaler, saturating centimetre counter and measurement timeout counter.
module hcsr04_echo_timer
  import hcsr04_pkg::*;
#(
  parameter int DIST_W      = 12,
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic              echo,
  output logic [DIST_W-1:0] cm,
  output logic              fim_timeout
);
  localparam int PW = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic tick;
  always_comb begin
    tick  = run & echo & (pre_q == PW'(CYC_PER_CM - 1));
    pre_d = clr ? '0 : (run & echo) ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    cm_d  = clr ? '0 : (tick && !(&cm_q)) ? cm_q + 1'b1 : cm_q;
    tmo_d = clr ? '0 : (run && !fim_timeout) ? tmo_q + 1'b1 : tmo_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pre_q <= '0;
      cm_q  <= '0;
      tmo_q <= '0;
    end else begin
      pre_q <= pre_d;
      cm_q  <= cm_d;
      tmo_q <= tmo_d;
    end
  assign cm          = cm_q;
  assign fim_timeout = tmo_q == TW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/interface_hcsr04_multi.sv
// interface_hcsr04_multi: round-robin HC-SR04 ranging of N_CH sensors on one shared echo timer.
// Define HCSR04_ECHO_SYNC_EN to pass every echo line through a two-flop synchroniser.
module interface_hcsr04_multi
  import hcsr04_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIST_W      = 12,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              continuo,
  input  logic              parar,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [DIST_W-1:0] medida,
  output logic [CH_W-1:0]   canal,
  output logic              pronto,
  output logic              timeout,
  output logic              fim_varredura,
  output logic              ocupado,
  output logic [3:0]        db_estado
);
  localparam int CNT_W = $clog2(((TRIG_CYC > SETTLE_CYC) ? TRIG_CYC : SETTLE_CYC) + 1);
  logic [2:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] ptr_q, ptr_d, canal_q, canal_d;
  logic [DIST_W-1:0] medida_q, medida_d, cm;
  logic cont_q, cont_d, stop_q, stop_d, pronto_q, pronto_d, tmo_q, tmo_d, fim_q, fim_d;
  logic echo_s, fim_tmo, last_ch, store, store_tmo;
`ifdef HCSR04_ECHO_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  assign echo_s = sync2_q[ptr_q];
`else
  assign echo_s = echo[ptr_q];
`endif
  hcsr04_echo_timer #(
    .DIST_W(DIST_W), .CYC_PER_CM(CYC_PER_CM), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock, .reset,
    .clr(state_q == S_TRIG),
    .run(state_q == S_WAIT || state_q == S_MEAS),
    .echo(echo_s),
    .cm,
    .fim_timeout(fim_tmo)
  );
  assign last_ch = ptr_q == CH_W'(N_CH - 1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    ptr_d     = ptr_q;
    cont_d    = cont_q;
    stop_d    = stop_q | (parar & (state_q != S_IDLE));
    store     = 1'b0;
    store_tmo = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (medir) begin
          state_d = S_TRIG;
          ptr_d   = '0;
          cont_d  = continuo;
          stop_d  = 1'b0;
        end
      end
      S_TRIG: if (cnt_q == CNT_W'(TRIG_CYC - 1)) state_d = S_WAIT;
      S_WAIT: begin
        store     = fim_tmo;
        store_tmo = fim_tmo;
        if (!fim_tmo && echo_s) state_d = S_MEAS;
      end
      // an echo fall on the timeout cycle still yields a valid distance
      S_MEAS: begin
        store     = !echo_s || fim_tmo;
        store_tmo = echo_s && fim_tmo;
      end
      S_STORE: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
        cnt_d   = '0;
        state_d = (stop_q || (last_ch && !cont_q)) ? S_IDLE : S_TRIG;
        ptr_d   = last_ch ? '0 : ptr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (store) state_d = S_STORE;
    medida_d = store ? (store_tmo ? '1 : cm) : medida_q;
    canal_d  = store ? ptr_q : canal_q;
    tmo_d    = store ? store_tmo : tmo_q;
    pronto_d = store;
    fim_d    = store & last_ch;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      cont_q   <= 1'b0;
      stop_q   <= 1'b0;
      medida_q <= '0;
      canal_q  <= '0;
      tmo_q    <= 1'b0;
      pronto_q <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      cont_q   <= cont_d;
      stop_q   <= stop_d;
      medida_q <= medida_d;
      canal_q  <= canal_d;
      tmo_q    <= tmo_d;
      pronto_q <= pronto_d;
      fim_q    <= fim_d;
    end
  assign trigger       = N_CH'(state_q == S_TRIG) << ptr_q;
  assign medida        = medida_q;
  assign canal         = canal_q;
  assign pronto        = pronto_q;
  assign timeout       = tmo_q;
  assign fim_varredura = fim_q;
  assign ocupado       = state_q != S_IDLE;
  assign db_estado     = db_code(state_q);
endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// tb_interface_hcsr04_multi: randomised scoreboard bench; a sensor model issues echoes and queues the
// expected result, a monitor checks every pronto against the queue.
module tb_interface_hcsr04_multi;
  localparam int N_CH = 4, DIST_W = 4, TRIG_CYC = 5, CPC = 4, TMO = 100, SETTLE = 3;
  localparam int MAXV = (1 << DIST_W) - 1;
  logic clock = 1'b0, reset = 1'b1, medir = 1'b0, continuo = 1'b0, parar = 1'b0;
  logic [N_CH-1:0] echo = '0;
  logic [N_CH-1:0] trigger;
  logic [DIST_W-1:0] medida;
  logic [1:0] canal;
  logic pronto, timeout, fim_varredura, ocupado;
  logic [3:0] db_estado;

  interface_hcsr04_multi #(
    .N_CH(N_CH), .DIST_W(DIST_W), .TRIG_CYC(TRIG_CYC), .CYC_PER_CM(CPC),
    .TIMEOUT_CYC(TMO), .SETTLE_CYC(SETTLE)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .continuo(continuo), .parar(parar),
    .echo(echo), .trigger(trigger), .medida(medida), .canal(canal), .pronto(pronto),
    .timeout(timeout), .fim_varredura(fim_varredura), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { int m; int c; bit t; bit f; int due; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, npronto = 0;
  bit rnd = 1'b0, first_trig = 1'b0;
  int pd[N_CH], ph[N_CH];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Echo starts d clocks after the trigger falls and stays high h clocks (h=0: never answers).
  function automatic void model(input int d, input int h, output int m, output bit t, output int lat);
    if (h > 0 && d + h <= TMO - 1) begin
      t = 1'b0;
      m = (h / CPC > MAXV) ? MAXV : h / CPC;
      lat = d + h + 1;
    end else begin
      t = 1'b1;
      m = MAXV;
      lat = TMO;
    end
  endfunction

  initial begin : sensor
    int act, k, d, h, exp_ch, trig_len, last_due, m, lat;
    bit meas, t;
    logic [N_CH-1:0] prev_tr, e;
    exp_t x;
    act = -1; meas = 1'b0; prev_tr = '0; trig_len = 0; last_due = 0; k = 0; d = 0; h = 0;
    forever begin
      tick();
      if (!reset) begin
        act = -1; meas = 1'b0; prev_tr = '0; trig_len = 0; echo = '0;
      end else begin
        if (trigger != '0 && prev_tr == '0) begin
          exp_ch = first_trig ? 0 : (act + 1) % N_CH;
          if (!first_trig) chk("trig_spacing", cyc, last_due + SETTLE + 1);
          chk("trig_sel", int'(trigger), 1 << exp_ch);
          first_trig = 1'b0; act = exp_ch; meas = 1'b0; trig_len = 0;
        end
        if (trigger != '0) trig_len++;
        if (act >= 0 && prev_tr[act] && !trigger[act]) begin
          chk("trig_len", trig_len, TRIG_CYC);
          if (rnd) begin
            d = $urandom_range(0, 20);
            h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 110);
          end else begin
            d = pd[act];
            h = ph[act];
          end
          model(d, h, m, t, lat);
          last_due = cyc + lat;
          x.m = m; x.c = act; x.t = t; x.f = (act == N_CH - 1); x.due = last_due;
          sb.push_back(x);
          meas = 1'b1; k = 0;
        end
        e = N_CH'($urandom());
        if (act >= 0) e[act] = meas && k >= d && k < d + h;
        echo = e;
        if (meas) k++;
        prev_tr = trigger;
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      tick();
      if (reset && pronto) begin
        npronto++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pronto: canal %0d medida %0d with nothing expected", canal, medida);
        end else begin
          x = sb.pop_front();
          chk("medida", int'(medida), x.m);
          chk("canal", int'(canal), x.c);
          chk("timeout", int'(timeout), int'(x.t));
          chk("fim_varredura", int'(fim_varredura), int'(x.f));
          chk("pronto_cycle", cyc, x.due);
        end
      end else if (fim_varredura) chk("fim_without_pronto", int'(fim_varredura), int'(pronto));
    end
  end

  task automatic check_reset();
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_medida", int'(medida), 0);
    chk("rst_canal", int'(canal), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_fim", int'(fim_varredura), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_estado", int'(db_estado), 0);
  endtask

  task automatic start_scan(input bit cont);
    first_trig = 1'b1; continuo = cont; medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("trig0_rise", int'(trigger), 1);
    chk("ocupado_hi", int'(ocupado), 1);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (ocupado && n < maxc) begin tick(); n++; end
    chk("scan_end", int'(ocupado), 0);
  endtask

  task automatic wait_state(input int s, input int maxc);
    int n = 0;
    while (int'(db_estado) != s && n < maxc) begin tick(); n++; end
    chk("reach_state", int'(db_estado), s);
  endtask

  task automatic scan_once(input bit poke_medir);
    int base = npronto;
    start_scan(1'b0);
    if (poke_medir) begin
      wait_state(3, 100);
      medir = 1'b1;
      tick();
      medir = 1'b0;
    end
    wait_idle(3000);
    chk("prontos_per_scan", npronto - base, N_CH);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin : main
    int base, n;
    #1 reset = 1'b0;
    #2 check_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    rnd = 1'b0;
    ph = '{40, 41, 43, 44};
    for (int i = 0; i < N_CH; i++) pd[i] = $urandom_range(0, 5);
    scan_once(1'b1);
    pd = '{2, 0, 9, 10};
    ph = '{90, 0, 90, 90};
    scan_once(1'b0);
    rnd = 1'b1;
    repeat (3) scan_once(1'b0);
    base = npronto;
    start_scan(1'b1);
    n = 0;
    while (npronto < base + N_CH + 1 && n < 3000) begin tick(); n++; end
    chk("cont_wrapped", int'(npronto >= base + N_CH + 1), 1);
    n = 0;
    while (!trigger[1] && n < 400) begin tick(); n++; end
    chk("cont_trig1", int'(trigger[1]), 1);
    parar = 1'b1;
    tick();
    parar = 1'b0;
    wait_idle(2000);
    chk("cont_prontos", npronto - base, N_CH + 2);
    chk("cont_last_canal", int'(canal), 1);
    chk("sb_empty", sb.size(), 0);
    rnd = 1'b0;
    pd = '{3, 1, 1, 1};
    ph = '{40, 40, 40, 40};
    start_scan(1'b0);
    wait_state(3, 100);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_reset();
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    scan_once(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end
endmodule
